pool1_engine: RTL
=================

POOL1_ENGINE -- requirements
Module: pool1_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel/feature width in bits (two's complement).
REQ-002 SHALL have parameter IN_DIM, default 24, conv1 feature-map side length; must be even.
REQ-003 SHALL have parameter RELU_EN, default 1; 1 clamps pooled output at zero.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to pool one full feature map.
REQ-007 SHALL have ports rd_addr0..rd_addr3  output  10 each  conv1 memory read addresses for one 2x2 window.
REQ-008 SHALL have ports rd_data0..rd_data3  input  DATA_W each  conv1 read data, valid one cycle after the matching address.
REQ-009 SHALL have port wr_addr  output  8  P1 memory write address.
REQ-010 SHALL have port wr_data  output  DATA_W  pooled value.
REQ-011 SHALL have port wr_en  output  1  P1 write strobe.
REQ-012 SHALL have port busy  output  1  high from start acceptance until done.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-015 SHALL sample start only in IDLE; start in any other state is ignored.
REQ-016 SHALL on accepted start go to ISSUE next cycle with window row r=0, column c=0, and assert busy.
REQ-017 SHALL in ISSUE present registered addresses: rd_addr0=2*IN_DIM*r+2c, rd_addr1=rd_addr0+1, rd_addr2=rd_addr0+IN_DIM, rd_addr3=rd_addr0+IN_DIM+1.
REQ-018 SHALL advance one window per cycle, c first; at c=IN_DIM/2-1, c wraps to 0 and r increments.
REQ-019 SHALL go ISSUE->DRAIN after issuing window r=c=IN_DIM/2-1 (default addresses 550,551,574,575).
REQ-020 SHALL compute signed max of the four rd_data words in the cycle they are valid and register it to wr_data with wr_en=1 the following cycle (2-cycle latency address->write).
REQ-021 SHALL, when RELU_EN=1, output 0 for a negative maximum; when RELU_EN=0, output the maximum unchanged.
REQ-022 SHALL write windows in issue order to wr_addr 0..(IN_DIM/2)^2-1 (default 0..143), incrementing by 1 per write, no gaps.
REQ-023 SHALL stay in DRAIN for 2 cycles, then return to IDLE.
REQ-024 SHALL pulse done in the same cycle as the final wr_en, deassert busy the next cycle; start is ignored while done is high and accepted from the following cycle.
REQ-025 SHALL take exactly (IN_DIM/2)^2+2 cycles from first ISSUE cycle to done (default 146).
REQ-026 SHALL hold rd_addr*, wr_addr, wr_data stable and wr_en=0 whenever no write is being performed.

Reset
REQ-027 SHALL on reset low, immediately and regardless of state, drive rd_addr*, wr_addr, wr_data to 0 and wr_en, busy, done to 0, and enter IDLE.
REQ-028 SHALL discard any in-flight window on mid-operation reset; no wr_en after reset release until a new start.

Structure
REQ-029 SHALL take DATA_W default, CONV1_DIM=24, P1_DIM=12, address widths and the FSM state enum from shared package cnn_pkg.
REQ-030 SHALL instantiate one sub-module max4_relu (four signed inputs, RELU_EN parameter, combinational max).

Verification
REQ-031 Ramp map (word = address), start -> wr_addr 0 data 25, wr_addr 143 data 575, done 146 cycles after first ISSUE.
REQ-032 Address check -> window 12 issues 48,49,72,73; window 13 issues 50,51,74,75.
REQ-033 All words -5: RELU_EN=1 -> 144 writes of 0; RELU_EN=0 -> 144 writes of -5.
REQ-034 Window {0x8000,0x7FFF,0x0001,0xFFFF} -> wr_data 0x7FFF.
REQ-035 Reset pulsed after write 50 -> all outputs 0 immediately, no further wr_en; new start -> full 144 writes from wr_addr 0.
REQ-036 start held high throughout run and during done cycle -> exactly one run; start next cycle -> second run begins.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants and types for the CNN layer engines:
//                default feature width, conv1/P1 map sizes, memory address
//                widths and the pooling engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   localparam int CNN_DATA_W = 16;             // default pixel/feature width
   localparam int CONV1_DIM  = 24;             // conv1 feature-map side
   localparam int P1_DIM     = CONV1_DIM / 2;  // pooled map side
   localparam int RD_ADDR_W  = 10;             // conv1 memory address width
   localparam int WR_ADDR_W  = 8;              // P1 memory address width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } pool_state_t;

endpackage
`default_nettype wire

// File: rtl/pool1_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool1_engine_if
//  Description : Bundle of the pooling engine's control and memory signals.
//                master : engine side (drives addresses, write port, status)
//                slave  : environment side (drives start and read data)
//  Signals     : start, rd_addr0..3, rd_data0..3, wr_addr, wr_data, wr_en,
//                busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface pool1_engine_if
   import cnn_pkg::*;
#(
   parameter int DATA_W = CNN_DATA_W
);

   logic                 start;
   logic [RD_ADDR_W-1:0] rd_addr0;
   logic [RD_ADDR_W-1:0] rd_addr1;
   logic [RD_ADDR_W-1:0] rd_addr2;
   logic [RD_ADDR_W-1:0] rd_addr3;
   logic [DATA_W-1:0]    rd_data0;
   logic [DATA_W-1:0]    rd_data1;
   logic [DATA_W-1:0]    rd_data2;
   logic [DATA_W-1:0]    rd_data3;
   logic [WR_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic                 wr_en;
   logic                 busy;
   logic                 done;

   modport master (
      input  start, rd_data0, rd_data1, rd_data2, rd_data3,
      output rd_addr0, rd_addr1, rd_addr2, rd_addr3,
      output wr_addr, wr_data, wr_en, busy, done
   );

   modport slave (
      output start, rd_data0, rd_data1, rd_data2, rd_data3,
      input  rd_addr0, rd_addr1, rd_addr2, rd_addr3,
      input  wr_addr, wr_data, wr_en, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/pool1_engine_max4_relu.sv
`default_nettype none
// ============================================================================
//  Module      : max4_relu
//  Description : Combinational signed maximum of four words with optional
//                clamp of negative results to zero.
//  Ports       : a, b, c, d (in, signed DATA_W) - window words
//                y          (out, DATA_W)       - pooled value
//  Revision    : 1.0 - initial release
// ============================================================================
module max4_relu #(
   parameter int DATA_W  = 16,
   parameter int RELU_EN = 1
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [DATA_W-1:0] c,
   input  logic signed [DATA_W-1:0] d,
   output logic        [DATA_W-1:0] y
);

   logic signed [DATA_W-1:0] w_max_ab;
   logic signed [DATA_W-1:0] w_max_cd;
   logic signed [DATA_W-1:0] w_max;

   always_comb begin
      w_max_ab = (a > b) ? a : b;
      w_max_cd = (c > d) ? c : d;
      w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
   end

   generate
      if (RELU_EN != 0) begin : g_relu
         assign y = w_max[DATA_W-1] ? '0 : w_max;
      end else begin : g_pass
         assign y = w_max;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pool1_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pool1_engine
//  Description : 2x2 / stride-2 max-pooling engine. On start it walks every
//                2x2 window of the IN_DIM x IN_DIM conv1 map (one per cycle,
//                column first), reads the four words, and writes the signed
//                maximum (optionally ReLU-clamped) to consecutive P1 addresses.
//  Ports       : clk   (in)  - clock, rising edge
//                reset (in)  - asynchronous, active-low reset
//                bus   (pool1_engine_if.master) - start, 4 read ports,
//                        write port, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
module pool1_engine
   import cnn_pkg::*;
#(
   parameter int DATA_W  = CNN_DATA_W,
   parameter int IN_DIM  = CONV1_DIM,
   parameter int RELU_EN = 1
) (
   input  logic           clk,
   input  logic           reset,
   pool1_engine_if.master bus
);

   localparam int                   c_half     = IN_DIM / 2;
   localparam logic [RD_ADDR_W-1:0] c_last_idx = RD_ADDR_W'(c_half - 1);
   localparam logic [RD_ADDR_W-1:0] c_dim      = RD_ADDR_W'(IN_DIM);
   // From the last window of a row pair to the first of the next pair:
   // skip the rest of the current row plus the whole second row.
   localparam logic [RD_ADDR_W-1:0] c_row_step = RD_ADDR_W'(IN_DIM + 2);

   pool_state_t          r_state;
   pool_state_t          w_next_state;
   logic                 w_accept;
   logic                 w_last_col;
   logic                 w_last_win;
   logic [RD_ADDR_W-1:0] w_next_base;

   logic [RD_ADDR_W-1:0] r_col;
   logic [RD_ADDR_W-1:0] r_row;
   logic [RD_ADDR_W-1:0] r_rd_addr0;
   logic [RD_ADDR_W-1:0] r_rd_addr1;
   logic [RD_ADDR_W-1:0] r_rd_addr2;
   logic [RD_ADDR_W-1:0] r_rd_addr3;
   logic                 r_data_vld;   // read data for an issued window is on rd_data*
   logic                 r_drain_cnt;
   logic [WR_ADDR_W-1:0] r_wr_cnt;
   logic [WR_ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0]    r_wr_data;
   logic                 r_wr_en;
   logic                 r_done;
   logic [DATA_W-1:0]    w_pooled;

   assign w_last_col  = (r_col == c_last_idx);
   assign w_last_win  = w_last_col && (r_row == c_last_idx);
   assign w_next_base = r_rd_addr0 + (w_last_col ? c_row_step : RD_ADDR_W'(2));

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next_state = ISSUE;
               w_accept     = 1'b1;
            end
         end
         ISSUE: begin
            if (w_last_win) begin
               w_next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (r_drain_cnt) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // Address walk, read-data pipeline and write port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col       <= '0;
         r_row       <= '0;
         r_rd_addr0  <= '0;
         r_rd_addr1  <= '0;
         r_rd_addr2  <= '0;
         r_rd_addr3  <= '0;
         r_data_vld  <= 1'b0;
         r_drain_cnt <= 1'b0;
         r_wr_cnt    <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_data_vld  <= (r_state == ISSUE);
         r_drain_cnt <= (r_state == DRAIN) && !r_drain_cnt;
         // The last write leaves the pipe on the second drain cycle.
         r_done      <= (r_state == DRAIN) && !r_drain_cnt;
         r_wr_en     <= r_data_vld;

         if (w_accept) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rd_addr0 <= '0;
            r_rd_addr1 <= RD_ADDR_W'(1);
            r_rd_addr2 <= c_dim;
            r_rd_addr3 <= c_dim + RD_ADDR_W'(1);
            r_wr_cnt   <= '0;
         end else if ((r_state == ISSUE) && !w_last_win) begin
            if (w_last_col) begin
               r_col <= '0;
               r_row <= r_row + RD_ADDR_W'(1);
            end else begin
               r_col <= r_col + RD_ADDR_W'(1);
            end
            r_rd_addr0 <= w_next_base;
            r_rd_addr1 <= w_next_base + RD_ADDR_W'(1);
            r_rd_addr2 <= w_next_base + c_dim;
            r_rd_addr3 <= w_next_base + c_dim + RD_ADDR_W'(1);
         end

         if (r_data_vld) begin
            r_wr_data <= w_pooled;
            r_wr_addr <= r_wr_cnt;
            r_wr_cnt  <= r_wr_cnt + WR_ADDR_W'(1);
         end
      end
   end

   max4_relu #(
      .DATA_W  (DATA_W),
      .RELU_EN (RELU_EN)
   ) u_max4_relu (
      .a (bus.rd_data0),
      .b (bus.rd_data1),
      .c (bus.rd_data2),
      .d (bus.rd_data3),
      .y (w_pooled)
   );

   assign bus.rd_addr0 = r_rd_addr0;
   assign bus.rd_addr1 = r_rd_addr1;
   assign bus.rd_addr2 = r_rd_addr2;
   assign bus.rd_addr3 = r_rd_addr3;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.wr_en    = r_wr_en;
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = r_done;

endmodule
`default_nettype wire
